// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide unit with HI/LO results
// Optional signed operation (op[1]=1) is built only when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] hi,
   output logic [n-1:0] lo,
   output logic         div_by_zero
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   localparam int cw = $clog2(n + 1);

   state_t         state;
   logic [cw-1:0]  count;
   logic [n-1:0]   acc;      // multiply: running high half; divide: partial remainder
   logic [n-1:0]   mq;       // multiply: multiplier / low product; divide: dividend / quotient
   logic [n-1:0]   opb;      // multiply: multiplicand; divide: divisor
   logic [n-1:0]   raw_a;    // untouched operand A, returned as remainder on divide by zero
   logic           b_zero;

   logic [n-1:0]   mag_a;
   logic [n-1:0]   mag_b;
   logic [n:0]     mul_sum;
   logic [n:0]     div_shift;
   logic [n-1:0]   div_diff;
   logic           div_ge;
   logic [2*n-1:0] prod_fix;
   logic [n-1:0]   quo_fix;
   logic [n-1:0]   rem_fix;

`ifdef MULDIV_SIGNED_EN
   logic           neg_q;    // product / quotient must be negated at the end
   logic           neg_r;    // remainder takes the sign of the dividend
   logic           sa;
   logic           sb;

   // Operand magnitudes for the unsigned core, plus final sign fix-up
   always_comb begin
      sa       = op[1] & a[n-1];
      sb       = op[1] & b[n-1];
      mag_a    = sa ? -a : a;
      mag_b    = sb ? -b : b;
      prod_fix = neg_q ? -{acc, mq} : {acc, mq};
      quo_fix  = neg_q ? -mq : mq;
      rem_fix  = neg_r ? -acc : acc;
   end
`else
   logic unused_sign;
   assign unused_sign = op[1];

   // Unsigned only: operands and results pass straight through
   always_comb begin
      mag_a    = a;
      mag_b    = b;
      prod_fix = {acc, mq};
      quo_fix  = mq;
      rem_fix  = acc;
   end
`endif

   // One iteration step of each algorithm; the n+1-bit adder keeps the multiply carry
   always_comb begin
      mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opb} : {(n+1){1'b0}});
      div_shift = {acc, mq[n-1]};
      div_ge    = (div_shift >= {1'b0, opb});
      div_diff  = div_shift[n-1:0] - opb;
   end

   // Control FSM, datapath iteration and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         count       <= '0;
         acc         <= '0;
         mq          <= '0;
         opb         <= '0;
         raw_a       <= '0;
         b_zero      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               busy <= 1'b0;
               if (start) begin
                  // hi/lo keep their old values until the new result lands
                  state       <= op[0] ? DIV : MUL;
                  div_by_zero <= 1'b0;
                  count       <= '0;
                  acc         <= '0;
                  mq          <= op[0] ? mag_a : mag_b;
                  opb         <= op[0] ? mag_b : mag_a;
                  raw_a       <= a;
                  b_zero      <= (b == '0);
`ifdef MULDIV_SIGNED_EN
                  neg_q       <= sa ^ sb;
                  neg_r       <= sa;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            MUL: begin
               if (count == cw'(n)) begin
                  {hi, lo} <= prod_fix;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end else begin
                  acc   <= mul_sum[n:1];
                  mq    <= {mul_sum[0], mq[n-1:1]};
                  count <= count + 1'b1;
                  busy  <= 1'b1;
               end
            end
            DIV: begin
               if (count == cw'(n)) begin
                  if (b_zero) begin
                     lo          <= '1;
                     hi          <= raw_a;
                     div_by_zero <= 1'b1;
                  end else begin
                     lo <= quo_fix;
                     hi <= rem_fix;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else if (b_zero) begin
                  // Skip all iterations; finish on the following edge
                  count <= cw'(n);
                  busy  <= 1'b1;
               end else begin
                  acc   <= div_ge ? div_diff : div_shift[n-1:0];
                  mq    <= {mq[n-2:0], div_ge};
                  count <= count + 1'b1;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed table-driven bench for muldiv_unit
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.n(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      logic        edbz;
      int          elat;
      int          ebusy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one op, wait (bounded) for done; lat counts edges after the accepting edge
   task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int lat, output int busy_cnt);
      op = o; a = va; b = vb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      lat = 0; busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         lat++;
         if (busy) busy_cnt++;
         if (done) break;
      end
   endtask

   initial begin
      int lat;
      int bc;
      int dcount;
      int dcycle;
      logic [31:0] held_hi;
      logic [31:0] held_lo;

      vecs.push_back('{2'b00, 32'd7,         32'd6,          32'd0,         32'd42,        1'b0, 33, 32});
      vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 32});
      vecs.push_back('{2'b01, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0, 33, 32});
      vecs.push_back('{2'b01, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1'b1, 2,  1});
      vecs.push_back('{2'b00, 32'h1234_5678, 32'h10,         32'd1,         32'h2345_6780, 1'b0, 33, 32});
      vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'h10,         32'hF,         32'h0FFF_FFFF, 1'b0, 33, 32});
      vecs.push_back('{2'b01, 32'd3,         32'd7,          32'd3,         32'd0,         1'b0, 33, 32});
`ifdef MULDIV_SIGNED_EN
      vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 32});
      vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 1'b0, 33, 32});
      vecs.push_back('{2'b10, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, 32});
      vecs.push_back('{2'b11, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2,  1});
`else
      vecs.push_back('{2'b10, 32'hFFFF_FFFD, 32'd5,          32'd4,         32'hFFFF_FFF1, 1'b0, 33, 32});
      vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,          32'd1,         32'h7FFF_FFFC, 1'b0, 33, 32});
`endif

      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
      check("reset_hi", {32'd0, hi}, 64'd0);
      check("reset_lo", {32'd0, lo}, 64'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
         check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].elat));
         check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].ebusy));
         check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].ehi});
         check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].elo});
         check($sformatf("v%0d_dbz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].edbz});
         repeat (2) @(posedge clk);
         #1;
         check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
         check($sformatf("v%0d_hold_lo", i), {32'd0, lo}, {32'd0, vecs[i].elo});
      end

      // start pulses mid-multiply must be ignored
      op = 2'b00; a = 32'd11; b = 32'd13; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dcount = 0; dcycle = 0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin dcount++; dcycle = c; end
         if (c == 5 || c == 20) begin
            start = 1'b1; op = 2'b01; a = 32'd99; b = 32'd3;
         end
      end
      check("ignore_start_done_count", 64'(dcount), 64'd1);
      check("ignore_start_done_cycle", 64'(dcycle), 64'd33);
      check("ignore_start_lo", {32'd0, lo}, 64'd143);
      check("ignore_start_hi", {32'd0, hi}, 64'd0);

      // start held high through DONE: second op accepted with no IDLE gap
      op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      a = 32'd5; b = 32'd6;
      lat = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
      end
      check("b2b_first_lat", 64'(lat), 64'd33);
      check("b2b_first_lo", {32'd0, lo}, 64'd12);
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
      end
      check("b2b_second_lat", 64'(lat), 64'd33);
      check("b2b_second_lo", {32'd0, lo}, 64'd30);

      // reset aborts a divide in flight
      op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_abort_busy", {63'd0, busy}, 64'd0);
      check("rst_abort_hi", {32'd0, hi}, 64'd0);
      check("rst_abort_lo", {32'd0, lo}, 64'd0);
      rst = 1'b0;
      dcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      check("rst_abort_no_done", 64'(dcount), 64'd0);
      run_op(2'b00, 32'd3, 32'd3, lat, bc);
      check("post_rst_lat", 64'(lat), 64'd33);
      check("post_rst_lo", {32'd0, lo}, 64'd9);
      held_hi = hi;
      held_lo = lo;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_hold_hi", {32'd0, held_hi}, 64'd0);
      check("post_rst_hold_lo", {32'd0, lo}, {32'd0, held_lo});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
